// File: rtl/sha256_id_issuer.sv
// Tags incoming packet configs with a rolling ID and queues {id,last} for the SHA-256 ID validator.
// Optional macro SHA256_ID_ISSUER_RETIRE_EN adds id_retire and an outstanding-ID limit.
module sha256_id_issuer #(
  parameter int ID_W         = 6,
  parameter int SIZE_W       = 64,
  parameter int ID_BUF_DEPTH = 8
`ifdef SHA256_ID_ISSUER_RETIRE_EN
  , parameter int MAX_OUTSTAND = 63
`endif
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             en,
  input  logic                             sync_rst,
`ifdef SHA256_ID_ISSUER_RETIRE_EN
  input  logic                             id_retire,
`endif
  input  logic [SIZE_W-1:0]                cfg_in_size,
  input  logic [1:0]                       cfg_in_scheme,
  input  logic                             cfg_in_last,
  input  logic                             cfg_in_valid,
  output logic                             cfg_in_ready,
  output logic [SIZE_W-1:0]                cfg_out_size,
  output logic [1:0]                       cfg_out_scheme,
  output logic [ID_W-1:0]                  cfg_out_id,
  output logic                             cfg_out_last,
  output logic                             cfg_out_valid,
  input  logic                             cfg_out_ready,
  output logic [ID_W-1:0]                  id_out,
  output logic                             id_out_last,
  output logic                             id_out_valid,
  input  logic                             id_out_ready,
  output logic [ID_W-1:0]                  status_next_id,
  output logic [$clog2(ID_BUF_DEPTH):0]    status_fifo_lvl
);
  localparam int PTR_W = $clog2(ID_BUF_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ID_W + 1;

  logic              clr;
  logic              accept, push, pop, fifo_full, room;
  logic [ENT_W-1:0]  push_ent;

  logic [ID_W-1:0]   next_id_q, next_id_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [1:0]        scheme_q, scheme_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              last_q, last_d;
  logic              cvld_q, cvld_d;

  logic [ENT_W-1:0]  mem_q [ID_BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic [ENT_W-1:0]  head_q, head_d;

  assign clr       = ~nrst | sync_rst;
  assign fifo_full = (lvl_q == LVL_W'(ID_BUF_DEPTH));
  assign push_ent  = {next_id_q, cfg_in_last};

`ifdef SHA256_ID_ISSUER_RETIRE_EN
  localparam int OUT_W = $clog2(MAX_OUTSTAND + 1);
  logic [OUT_W-1:0] outst_q, outst_d;
  logic             retire_ok;

  assign room      = (outst_q < OUT_W'(MAX_OUTSTAND));
  assign retire_ok = id_retire & (outst_q != '0);

  always_comb begin
    outst_d = outst_q;
    unique case ({accept, retire_ok})
      2'b10:   outst_d = outst_q + OUT_W'(1);
      2'b01:   outst_d = outst_q - OUT_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) outst_q <= '0;
    else     outst_q <= outst_d;
  end
`else
  assign room = 1'b1;
`endif

  // No pass-through: a full FIFO blocks acceptance even when it pops this cycle.
  assign cfg_in_ready = ~clr & en & ~fifo_full & (~cvld_q | cfg_out_ready) & room;
  assign accept       = cfg_in_valid & cfg_in_ready;
  assign push         = accept;
  assign pop          = (lvl_q != '0) & id_out_ready;

  always_comb begin
    next_id_d = next_id_q;
    size_d    = size_q;
    scheme_d  = scheme_q;
    id_d      = id_q;
    last_d    = last_q;
    cvld_d    = cvld_q;
    if (accept) begin
      size_d    = cfg_in_size;
      scheme_d  = cfg_in_scheme;
      id_d      = next_id_q;
      last_d    = cfg_in_last;
      cvld_d    = 1'b1;
      next_id_d = next_id_q + ID_W'(1);
    end else if (cvld_q && cfg_out_ready) begin
      cvld_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    lvl_d    = lvl_q;
    unique case ({push, pop})
      2'b10:   lvl_d = lvl_q + LVL_W'(1);
      2'b01:   lvl_d = lvl_q - LVL_W'(1);
      default: lvl_d = lvl_q;
    endcase
    // Head register tracks the next oldest entry; a push into an empty queue lands here directly.
    if (lvl_d == '0)
      head_d = '0;
    else if (push && (wr_ptr_q == rd_ptr_d))
      head_d = push_ent;
    else
      head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_ent;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      next_id_q <= '0;
      size_q    <= '0;
      scheme_q  <= '0;
      id_q      <= '0;
      last_q    <= 1'b0;
      cvld_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      lvl_q     <= '0;
      head_q    <= '0;
    end else begin
      next_id_q <= next_id_d;
      size_q    <= size_d;
      scheme_q  <= scheme_d;
      id_q      <= id_d;
      last_q    <= last_d;
      cvld_q    <= cvld_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      lvl_q     <= lvl_d;
      head_q    <= head_d;
    end
  end

  assign cfg_out_size    = size_q;
  assign cfg_out_scheme  = scheme_q;
  assign cfg_out_id      = id_q;
  assign cfg_out_last    = last_q;
  assign cfg_out_valid   = cvld_q;
  assign id_out          = head_q[ENT_W-1:1];
  assign id_out_last     = head_q[0];
  assign id_out_valid    = (lvl_q != '0);
  assign status_next_id  = next_id_q;
  assign status_fifo_lvl = lvl_q;
endmodule

// File: tb/tb_sha256_id_issuer.sv
// Bench for sha256_id_issuer: directed scenarios plus random traffic against a queue-based model.
module tb_sha256_id_issuer;
  localparam int ID_W   = 6;
  localparam int SIZE_W = 64;
  localparam int DEPTH  = 8;
`ifdef SHA256_ID_ISSUER_RETIRE_EN
  localparam int MAXO   = 4;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              nrst, en, sync_rst;
  logic [SIZE_W-1:0] cfg_in_size;
  logic [1:0]        cfg_in_scheme;
  logic              cfg_in_last, cfg_in_valid, cfg_in_ready;
  logic [SIZE_W-1:0] cfg_out_size;
  logic [1:0]        cfg_out_scheme;
  logic [ID_W-1:0]   cfg_out_id;
  logic              cfg_out_last, cfg_out_valid, cfg_out_ready;
  logic [ID_W-1:0]   id_out;
  logic              id_out_last, id_out_valid, id_out_ready;
  logic [ID_W-1:0]   status_next_id;
  logic [$clog2(DEPTH):0] status_fifo_lvl;
`ifdef SHA256_ID_ISSUER_RETIRE_EN
  logic              id_retire;
`endif

  sha256_id_issuer #(
    .ID_W(ID_W), .SIZE_W(SIZE_W), .ID_BUF_DEPTH(DEPTH)
`ifdef SHA256_ID_ISSUER_RETIRE_EN
    , .MAX_OUTSTAND(MAXO)
`endif
  ) dut (
    .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
`ifdef SHA256_ID_ISSUER_RETIRE_EN
    .id_retire(id_retire),
`endif
    .cfg_in_size(cfg_in_size), .cfg_in_scheme(cfg_in_scheme), .cfg_in_last(cfg_in_last),
    .cfg_in_valid(cfg_in_valid), .cfg_in_ready(cfg_in_ready),
    .cfg_out_size(cfg_out_size), .cfg_out_scheme(cfg_out_scheme), .cfg_out_id(cfg_out_id),
    .cfg_out_last(cfg_out_last), .cfg_out_valid(cfg_out_valid), .cfg_out_ready(cfg_out_ready),
    .id_out(id_out), .id_out_last(id_out_last), .id_out_valid(id_out_valid),
    .id_out_ready(id_out_ready), .status_next_id(status_next_id),
    .status_fifo_lvl(status_fifo_lvl)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: the tagged config slot, the ID queue, and counters.
  bit          m_cv;
  logic [63:0] m_size;
  logic [1:0]  m_scheme;
  int          m_id, m_next, m_acc, m_outst;
  bit          m_last;
  int          fifo[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready();
    bit r;
    r = nrst && !sync_rst && en && (fifo.size() < DEPTH) && (!m_cv || cfg_out_ready);
`ifdef SHA256_ID_ISSUER_RETIRE_EN
    r = r && (m_outst < MAXO);
`endif
    return r;
  endfunction

  task automatic m_clear();
    m_cv = 0; m_size = '0; m_scheme = '0; m_id = 0; m_last = 0;
    m_next = 0; m_outst = 0;
    fifo.delete();
  endtask

  task automatic m_update();
    bit rdy, acc, pp;
    if (!nrst || sync_rst) begin
      m_clear();
      return;
    end
    rdy = m_ready();
    acc = cfg_in_valid && rdy;
    pp  = (fifo.size() != 0) && id_out_ready;
    if (pp) void'(fifo.pop_front());
    if (acc) begin
      fifo.push_back(m_next * 2 + int'(cfg_in_last));
      m_acc++;
      m_cv = 1; m_size = cfg_in_size; m_scheme = cfg_in_scheme;
      m_id = m_next; m_last = cfg_in_last;
      m_next = (m_next + 1) % (1 << ID_W);
    end else if (m_cv && cfg_out_ready) begin
      m_cv = 0;
    end
`ifdef SHA256_ID_ISSUER_RETIRE_EN
    begin
      bit dec;
      dec = id_retire && (m_outst > 0);
      if (acc && !dec) m_outst++;
      else if (!acc && dec) m_outst--;
    end
`endif
  endtask

  task automatic check_all(input string ph);
    chk({ph, "_in_ready"},  cfg_in_ready,    m_ready());
    chk({ph, "_out_valid"}, cfg_out_valid,   m_cv);
    chk({ph, "_out_id"},    cfg_out_id,      m_id);
    chk({ph, "_out_size"},  cfg_out_size,    m_size);
    chk({ph, "_out_sch"},   cfg_out_scheme,  m_scheme);
    chk({ph, "_out_last"},  cfg_out_last,    m_last);
    chk({ph, "_id_valid"},  id_out_valid,    fifo.size() != 0);
    if (fifo.size() != 0) begin
      chk({ph, "_id_out"},  id_out,          fifo[0] / 2);
      chk({ph, "_id_last"}, id_out_last,     fifo[0] % 2);
    end
    chk({ph, "_next_id"},   status_next_id,  m_next);
    chk({ph, "_lvl"},       status_fifo_lvl, fifo.size());
  endtask

  // Inputs are driven at the falling edge before this call.
  task automatic cyc(input string ph);
    #1;
    check_all(ph);
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic rnd_fields();
    cfg_in_size   = {$urandom, $urandom};
    cfg_in_scheme = 2'($urandom_range(0, 3));
    cfg_in_last   = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int base;
    nrst = 0; sync_rst = 0; en = 1; cfg_in_valid = 0;
    cfg_out_ready = 1; id_out_ready = 1;
    cfg_in_size = '0; cfg_in_scheme = '0; cfg_in_last = 0;
`ifdef SHA256_ID_ISSUER_RETIRE_EN
    id_retire = 0;
`endif
    m_clear(); m_acc = 0;
    @(negedge clk); @(negedge clk);

    // Reset with all readies high
    cyc("rst"); cyc("rst");
    chk("rst_lvl", status_fifo_lvl, 0);
    chk("rst_in_ready_const", cfg_in_ready, 0);
    nrst = 1;

    // Three back-to-back configs
    for (int i = 0; i < 3; i++) begin
      cfg_in_valid = 1; rnd_fields(); cyc("t1");
    end
    chk("t1_cfg_id", cfg_out_id, 2);
    chk("t1_next_id", status_next_id, 3);
    chk("t1_id_out", id_out, 2);
    cfg_in_valid = 0;
    for (int i = 0; i < 4; i++) cyc("t1d");

    // FIFO fills to depth with id_out stalled
    id_out_ready = 0; base = m_acc;
    for (int i = 0; i < 12; i++) begin
      cfg_in_valid = 1; rnd_fields(); cyc("t2");
    end
    chk("t2_lvl_full", status_fifo_lvl, DEPTH);
    chk("t2_ready_low", cfg_in_ready, 0);
    chk("t2_next_id", status_next_id, 11);
    id_out_ready = 1;
    for (int i = 0; i < 20 && (m_acc - base) < 10; i++) begin
      rnd_fields(); cyc("t2r");
    end
    cfg_in_valid = 0;
    chk("t2_next_id_end", status_next_id, 13);
    for (int i = 0; i < 12; i++) cyc("t2d");

    // 65 packets: ID wrap
    nrst = 0; cyc("t3rst"); nrst = 1; base = m_acc;
    for (int i = 0; i < 400 && (m_acc - base) < 65; i++) begin
      cfg_in_valid = 1; rnd_fields();
      cfg_out_ready = ($urandom_range(0, 3) != 0);
      id_out_ready  = ($urandom_range(0, 3) != 0);
      cyc("t3");
    end
    cfg_in_valid = 0; cfg_out_ready = 1; id_out_ready = 1;
    chk("t3_count", m_acc - base, 65);
    chk("t3_cfg_id_wrap", cfg_out_id, 0);
    chk("t3_next_id", status_next_id, 1);
    for (int i = 0; i < 12; i++) cyc("t3d");

    // cfg_out_ready toggling
    for (int i = 0; i < 16; i++) begin
      cfg_in_valid = 1; rnd_fields(); cfg_out_ready = (i % 2 == 0); cyc("t4");
    end
    cfg_in_valid = 0; cfg_out_ready = 1;
    for (int i = 0; i < 12; i++) cyc("t4d");

    // sync_rst with 4 queued IDs and cfg_out holding
    nrst = 0; cyc("t5rst"); nrst = 1;
    id_out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      cfg_in_valid = 1; rnd_fields(); cyc("t5");
    end
    cfg_in_valid = 0; cfg_out_ready = 0;
    chk("t5_lvl4", status_fifo_lvl, 4);
    chk("t5_cvld", cfg_out_valid, 1);
    sync_rst = 1; cyc("t5s"); sync_rst = 0;
    chk("t5_cvld_clr", cfg_out_valid, 0);
    chk("t5_idv_clr", id_out_valid, 0);
    chk("t5_lvl_clr", status_fifo_lvl, 0);
    cfg_in_valid = 1; cfg_out_ready = 1; id_out_ready = 1; rnd_fields(); cyc("t5n");
    cfg_in_valid = 0;
    chk("t5_first_id", cfg_out_id, 0);
    chk("t5_first_vld", cfg_out_valid, 1);
    for (int i = 0; i < 4; i++) cyc("t5d");

`ifdef SHA256_ID_ISSUER_RETIRE_EN
    // Outstanding limit
    nrst = 0; cyc("t6rst"); nrst = 1;
    for (int i = 0; i < 8; i++) begin
      cfg_in_valid = 1; rnd_fields(); cyc("t6");
    end
    chk("t6_stall", cfg_in_ready, 0);
    chk("t6_next_id4", status_next_id, 4);
    id_retire = 1; cyc("t6r"); id_retire = 0;
    for (int i = 0; i < 4; i++) cyc("t6");
    chk("t6_next_id5", status_next_id, 5);
    cfg_in_valid = 0;
`endif

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      en            = ($urandom_range(0, 7) != 0);
      cfg_in_valid  = ($urandom_range(0, 9) < 7);
      cfg_out_ready = ($urandom_range(0, 9) < 6);
      id_out_ready  = ($urandom_range(0, 9) < 6);
      sync_rst      = ($urandom_range(0, 63) == 0);
`ifdef SHA256_ID_ISSUER_RETIRE_EN
      id_retire     = ($urandom_range(0, 9) < 3);
`endif
      rnd_fields();
      cyc("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
